// File: rtl/s_div_iter_pkg.sv
// Shared fixed-point helpers for the iterative signed divider: format derivation
// and the controller state encoding.
package s_div_iter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StFix,
    StDone
  } div_state_e;

  // Left shift applied to |dividend| so the quotient lands in the output format.
  function automatic int fx_shift(input int wf1, input int wf2, input int wfo);
    return wf2 - wf1 + wfo;
  endfunction

  function automatic int fx_wn(input int wi1, input int wf1, input int wf2, input int wfo);
    return wi1 + wf1 + fx_shift(wf1, wf2, wfo);
  endfunction

  function automatic longint unsigned fx_smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Magnitude of the most negative value of a signed w-bit word.
  function automatic longint unsigned fx_smin_mag(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/s_div_iter_if.sv
// Start/done handshake and operand/result bundle of the iterative divider.
interface s_div_iter_if #(
  parameter int unsigned W1 = 7,
  parameter int unsigned W2 = 7,
  parameter int unsigned WO = 19
) ();
  logic          start;
  logic [W1-1:0] in1;
  logic [W2-1:0] in2;
  logic          busy;
  logic          done;
  logic [WO-1:0] out;
  logic          ovf;
  logic          dz;

  modport master (output start, in1, in2, input busy, done, out, ovf, dz);
  modport slave  (input start, in1, in2, output busy, done, out, ovf, dz);
endinterface

// File: rtl/s_div_iter_div_step.sv
// One combinational restoring-division step: shift a dividend bit into the
// remainder and subtract the divisor when it fits.
module s_div_iter_div_step #(
  parameter int unsigned WD = 7
) (
  input  logic [WD:0]   r_in,
  input  logic          bit_in,
  input  logic [WD-1:0] d,
  output logic [WD:0]   r_out,
  output logic          q_bit
);
  logic [WD+1:0] r_sh;
  logic [WD+1:0] d_ext;

  always_comb begin
    r_sh  = {r_in, bit_in};
    d_ext = {2'b00, d};
    q_bit = (r_sh >= d_ext);
    // Remainder stays below D, so the dropped top bit is always zero.
    r_out = q_bit ? (WD+1)'(r_sh - d_ext) : r_sh[WD:0];
  end
endmodule

// File: rtl/s_div_iter.sv
// Iterative signed fixed-point divider: restoring division on magnitudes, one
// quotient bit per cycle, with sign fix-up, saturation and divide-by-zero flag.
module s_div_iter
  import s_div_iter_pkg::*;
#(
  parameter int WI1 = 4,
  parameter int WF1 = 3,
  parameter int WI2 = 2,
  parameter int WF2 = 5,
  parameter int WIO = 4,
  parameter int WFO = 15
) (
  input logic         CLK,
  input logic         RST,
  s_div_iter_if.slave bus
);
  localparam int S    = fx_shift(WF1, WF2, WFO);
  localparam int WN   = fx_wn(WI1, WF1, WF2, WFO);
  localparam int W1   = WI1 + WF1;
  localparam int W2   = WI2 + WF2;
  localparam int WO   = WIO + WFO;
  localparam int CW   = ((WN > WO) ? WN : WO) + 1;
  localparam int CntW = $clog2(WN + 1);

  localparam logic [WO-1:0] OutMax = WO'(fx_smax(WO));
  localparam logic [WO-1:0] OutMin = WO'(fx_smin_mag(WO));
  localparam logic [CW-1:0] PosLim = CW'(fx_smax(WO));
  localparam logic [CW-1:0] NegLim = CW'(fx_smin_mag(WO));

  if (S < 0) begin : g_bad_fmt
    $error("s_div_iter: WF2 - WF1 + WFO must be non-negative");
  end

  div_state_e    state_q, state_d;
  logic          sgn_q, sgn_d;
  logic          sa_q, sa_d;
  logic          zf_q, zf_d;
  logic [WN-1:0] num_q, num_d;
  logic [W2-1:0] den_q, den_d;
  logic [W2:0]   rem_q, rem_d;
  logic [WN-1:0] quo_q, quo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WO-1:0] out_q, out_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;

  logic [W1-1:0] abs1;
  logic [W2-1:0] abs2;
  logic [W2:0]   rem_nxt;
  logic          q_bit;
  logic [CW-1:0] quo_ext;
  logic [WO-1:0] quo_o;

  s_div_iter_div_step #(
    .WD (W2)
  ) u_div_step (
    .r_in   (rem_q),
    .bit_in (num_q[WN-1]),
    .d      (den_q),
    .r_out  (rem_nxt),
    .q_bit  (q_bit)
  );

  always_comb begin
    // Unsigned view makes 2^(W-1) from the most negative input representable.
    abs1    = bus.in1[W1-1] ? -bus.in1 : bus.in1;
    abs2    = bus.in2[W2-1] ? -bus.in2 : bus.in2;
    quo_ext = CW'(quo_q);
    quo_o   = WO'(quo_q);

    state_d = state_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    zf_d    = zf_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sgn_d   = bus.in1[W1-1] ^ bus.in2[W2-1];
          sa_d    = bus.in1[W1-1];
          num_d   = WN'(abs1) << S;
          den_d   = abs2;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          zf_d    = (bus.in2 == '0);
          state_d = (bus.in2 == '0) ? StFix : StDiv;
        end
      end
      StDiv: begin
        rem_d = rem_nxt;
        num_d = num_q << 1;
        quo_d = {quo_q[WN-2:0], q_bit};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WN - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StDone;
        ovf_d   = 1'b0;
        dz_d    = zf_q;
        if (zf_q) begin
          out_d = sa_q ? OutMin : OutMax;
        end else if (!sgn_q) begin
          if (quo_ext > PosLim) begin
            out_d = OutMax;
            ovf_d = 1'b1;
          end else begin
            out_d = quo_o;
          end
        end else begin
          if (quo_ext > NegLim) begin
            out_d = OutMin;
            ovf_d = 1'b1;
          end else begin
            out_d = -quo_o;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      zf_q    <= 1'b0;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      zf_q    <= zf_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.out  = out_q;
  assign bus.ovf  = ovf_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_s_div_iter.sv
// Bench for s_div_iter: directed cases, handshake/reset cases and random
// operands checked against an arithmetic reference model.
module tb_s_div_iter;
  localparam int WI1 = 4, WF1 = 3, WI2 = 2, WF2 = 5, WIO = 4, WFO = 15;
  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int WO = WIO + WFO;
  localparam int S  = WF2 - WF1 + WFO;
  localparam int WN = W1 + S;
  localparam int Timeout = 100;

  logic CLK = 1'b0;
  logic RST;

  s_div_iter_if #(.W1(W1), .W2(W2), .WO(WO)) bus ();

  s_div_iter #(
    .WI1 (WI1), .WF1 (WF1), .WI2 (WI2), .WF2 (WF2), .WIO (WIO), .WFO (WFO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Quotient from plain integer arithmetic on the real operand values.
  function automatic void ref_div(input logic [W1-1:0] a, input logic [W2-1:0] b,
                                  output logic [WO-1:0] o, output logic ov,
                                  output logic z);
    longint av, bv, mag, maxp, minm;
    av   = longint'($signed(a));
    bv   = longint'($signed(b));
    maxp = (longint'(1) << (WO - 1)) - 1;
    minm = longint'(1) << (WO - 1);
    ov = 1'b0;
    z  = 1'b0;
    if (bv == 0) begin
      z = 1'b1;
      o = (av < 0) ? WO'(minm) : WO'(maxp);
    end else begin
      mag = (((av < 0) ? -av : av) << S) / ((bv < 0) ? -bv : bv);
      if ((av < 0) == (bv < 0)) begin
        if (mag > maxp) begin o = WO'(maxp); ov = 1'b1; end
        else o = WO'(mag);
      end else begin
        if (mag > minm) begin o = WO'(minm); ov = 1'b1; end
        else o = WO'(-mag);
      end
    end
  endfunction

  // Starts an op in the next cycle; optionally pulses start again at cycle poke_at.
  task automatic run_op(input logic [W1-1:0] a, input logic [W2-1:0] b, input int poke_at,
                        output logic [WO-1:0] o, output logic ov, output logic z,
                        output int lat);
    @(posedge CLK); #1;
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    bus.in1   = W1'($urandom);
    bus.in2   = W2'($urandom);
    chk("busy_cycle1", 64'(bus.busy), 64'd1);
    lat = 1;
    while (bus.done !== 1'b1 && lat < Timeout) begin
      bus.start = (lat == poke_at);
      if (lat == poke_at) begin
        bus.in1 = W1'($urandom);
        bus.in2 = 7'h01;
      end
      @(posedge CLK); #1;
      lat++;
    end
    bus.start = 1'b0;
    o  = bus.out;
    ov = bus.ovf;
    z  = bus.dz;
  endtask

  typedef struct {
    logic [W1-1:0] a;
    logic [W2-1:0] b;
    logic [WO-1:0] o;
    logic          ov;
    logic          z;
    int            lat;
  } vec_t;

  vec_t dir [11] = '{
    '{7'd24,  7'd48,  19'h10000, 1'b0, 1'b0, 26},
    '{7'h68,  7'd48,  19'h70000, 1'b0, 1'b0, 26},
    '{7'd8,   7'd48,  19'h05555, 1'b0, 1'b0, 26},
    '{7'h78,  7'd48,  19'h7AAAB, 1'b0, 1'b0, 26},
    '{7'h3F,  7'd1,   19'h3FFFF, 1'b1, 1'b0, 26},
    '{7'h40,  7'd1,   19'h40000, 1'b1, 1'b0, 26},
    '{7'd8,   7'd0,   19'h3FFFF, 1'b0, 1'b1, 2},
    '{7'h78,  7'd0,   19'h40000, 1'b0, 1'b1, 2},
    '{7'd8,   7'h40,  19'h7C000, 1'b0, 1'b0, 26},
    '{7'd0,   7'd0,   19'h3FFFF, 1'b0, 1'b1, 2},
    '{7'd0,   7'h50,  19'h00000, 1'b0, 1'b0, 26}
  };

  initial begin
    logic [WO-1:0] o, eo;
    logic          ov, z, eov, ez;
    logic [W1-1:0] ra;
    logic [W2-1:0] rb;
    logic          seen;
    int            lat;

    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    RST       = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out",  64'(bus.out),  64'd0);
    chk("rst_ovf",  64'(bus.ovf),  64'd0);
    chk("rst_dz",   64'(bus.dz),   64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    RST = 1'b0;

    // Each op starts in the cycle right after the previous done.
    foreach (dir[i]) begin
      run_op(dir[i].a, dir[i].b, -1, o, ov, z, lat);
      chk($sformatf("dir%0d_out", i), 64'(o),  64'(dir[i].o));
      chk($sformatf("dir%0d_ovf", i), 64'(ov), 64'(dir[i].ov));
      chk($sformatf("dir%0d_dz",  i), 64'(z),  64'(dir[i].z));
      chk($sformatf("dir%0d_lat", i), 64'(lat), 64'(dir[i].lat));
    end

    @(posedge CLK); #1;
    chk("post_done_busy", 64'(bus.busy), 64'd0);
    chk("post_done_done", 64'(bus.done), 64'd0);
    chk("post_done_hold", 64'(bus.out),  64'(dir[10].o));

    run_op(7'd24, 7'd48, 5, o, ov, z, lat);
    chk("ign_start_out", 64'(o),   64'h10000);
    chk("ign_start_lat", 64'(lat), 64'(WN + 2));

    // Abort an op with reset at cycle 10.
    @(posedge CLK); #1;
    bus.start = 1'b1;
    bus.in1   = 7'd24;
    bus.in2   = 7'd48;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_out",  64'(bus.out),  64'd0);
    chk("abort_ovf",  64'(bus.ovf),  64'd0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge CLK); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ra = W1'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W2'($urandom);
      ref_div(ra, rb, eo, eov, ez);
      run_op(ra, rb, -1, o, ov, z, lat);
      chk($sformatf("rnd%0d_out a=%0h b=%0h", i, ra, rb), 64'(o), 64'(eo));
      chk($sformatf("rnd%0d_ovf", i), 64'(ov), 64'(eov));
      chk($sformatf("rnd%0d_dz",  i), 64'(z),  64'(ez));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), ez ? 64'd2 : 64'(WN + 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/s_div_iter.md
# s_div_iter

Iterative signed fixed-point divider: the inverse of the pipelined signed multiplier in the fixed-point arithmetic library. It computes `in1 / in2`, where both operands have independent Q(WI.WF) formats, and returns the result in a caller-chosen Q(WIO.WFO) format. It uses restoring division, one quotient bit per cycle, behind a start/done handshake. Out-of-range results saturate, and divide-by-zero is flagged.

## Interface
- `WI1`, default 4: integer bits of dividend, sign included.
- `WF1`, default 3: fraction bits of dividend.
- `WI2`, default 2: integer bits of divisor, sign included.
- `WF2`, default 5: fraction bits of divisor.
- `WIO`, default 4: integer bits of output, sign included.
- `WFO`, default 15: fraction bits of output.
- Derived constants:
  - `S = WF2 - WF1 + WFO`. S ≥ 0 is required, checked at elaboration.
  - `WN = WI1 + WF1 + S`.
- `CLK`, in, 1: single clock; all logic on rising edge.
- `RST`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: accepts operands when `busy` = 0.
- `in1`, in, WI1+WF1: signed dividend.
- `in2`, in, WI2+WF2: signed divisor.
- `busy`, out, 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done`, out, 1: one-cycle pulse; `out`, `ovf` and `dz` are valid from this cycle on.
- `out`, out, WIO+WFO: signed quotient. Held until the next `done`.
- `ovf`, out, 1: quotient saturated. Held with `out`.
- `dz`, out, 1: divisor was zero. Held with `out`.

## Operation
- States: IDLE, DIV, FIX, DONE.
- IDLE:
  - On `start`, latch `sgn = in1[msb] ^ in2[msb]` and `sA = in1[msb]`.
  - Latch `N = |in1| << S` (WN bits, unsigned) and `D = |in2|` (WI2+WF2 bits, unsigned). The value 2^(W-1) from the most negative input must be representable.
  - Clear the remainder and the bit counter, then go to DIV.
  - If `in2 == 0`, set a zero flag and go to FIX directly.
- DIV, one iteration per cycle:
  - `R = {R, N[msb]}`, then shift N left.
  - If R ≥ D: subtract D from R and shift 1 into Q; otherwise shift 0 into Q.
  - After exactly WN iterations go to FIX.
  - R is WI2+WF2+1 bits wide. Q is WN bits wide.
- FIX: rounding is truncation toward zero (magnitude truncation).
  - Positive result: if Q > 2^(WIO+WFO-1) − 1, output the maximum positive value and set `ovf`.
  - Negative result: if Q > 2^(WIO+WFO-1), output the most negative value and set `ovf`; otherwise output −Q.
  - Divide-by-zero: `dz` = 1 and `ovf` = 0. Output is the maximum positive value if `sA` = 0, the most negative value if `sA` = 1. This includes 0/0, which therefore gives the maximum positive value.
- DONE: pulse `done`, update `out`/`ovf`/`dz`, return to IDLE.
- `start` while `busy` = 1 is ignored. Operands are captured only at acceptance, so later changes to `in1`/`in2` have no effect.
- A zero dividend gives out = 0 (with −0 normalized to 0).

## Timing
- Reset values: `out` = 0, `ovf` = 0, `dz` = 0, `done` = 0, `busy` = 0, state IDLE.
- `RST` asserted mid-operation aborts the operation: next cycle the block is in IDLE, all outputs are at reset values, and no `done` is issued.
- Latency, with `start` accepted at edge 0:
  - `done` = 1 during cycle WN+2.
  - Divide-by-zero: `done` during cycle 2.
- `busy` = 1 for cycles 1 through WN+2. It drops in the cycle after `done`, when the block is back in IDLE.
- `start` sampled in the cycle after `done` is accepted, so back-to-back throughput is one operation per WN+3 cycles.
- With default parameters WN = 24, so `done` arrives at cycle 26.

## Structure
- A shared fixed-point package holds:
  - the format-derivation functions (S, WN, signed max/min of a WI.WF width);
  - the state enum (IDLE/DIV/FIX/DONE).
- One sub-module, `div_step`: combinational restoring step taking (R, next bit, D) and returning (R', q-bit). It is instantiated once.
- FSM, counters, sign handling and saturation stay in `s_div_iter`.

## Test plan
All cases use default parameters. Q4.3 dividend, Q2.5 divisor, Q4.15 output; output values are 19-bit hex.
- `in1` = 24 (3.0), `in2` = 48 (1.5) → `out` = 0x10000 (2.0), `ovf` = 0, `dz` = 0, `done` at cycle 26.
- `in1` = −24 (−3.0), `in2` = 48 → `out` = 0x70000 (−2.0). Then `in1` = 8 (1.0), `in2` = 48 → `out` = 0x05555. Then `in1` = −8, `in2` = 48 → `out` = 0x7AAAB (truncation toward zero).
- `in1` = 63 (7.875), `in2` = 1 (1/32) → `out` = 0x3FFFF, `ovf` = 1. Then `in1` = −64, `in2` = 1 → `out` = 0x40000, `ovf` = 1.
- `in1` = 8, `in2` = 0 → `out` = 0x3FFFF, `dz` = 1, `done` at cycle 2. Then `in1` = −8, `in2` = 0 → `out` = 0x40000, `dz` = 1.
- `in1` = 8, `in2` = −64 (−2.0) → `out` = 0x7C000 (−0.5). This exercises the most-negative divisor.
- Handshake and reset:
  - A `start` pulse at cycle 5 of an operation is ignored, and the result is unchanged.
  - `RST` at cycle 10 of an operation → no `done`, `out` = 0, `busy` = 0.
  - A new `start` in the cycle after `done` is accepted.
